// File: rtl/lsu_bus_bridge.sv
// Bridges the core data-memory port onto a pipelined valid/grant bus with lane steering and load extension.
// Latency: load >= 3 stall cycles (issue, grant, rvalid), store >= 2; DONE releases stall for one cycle.
// Backpressure: core is held via stall while the bus withholds gnt/rvalid, bounded by TIMEOUT cycles.
module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  tcnt;
    logic [1:0]  off_q;
    logic [2:0]  fn_q;

    logic        access, size_b, size_h, aligned, issue, expired;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign access  = mem_read | mem_write;
    assign size_b  = (funct == 3'b000) || (funct == 3'b100);
    assign size_h  = (funct == 3'b001) || (funct == 3'b101);
    assign aligned = size_b | (size_h & ~addr[0]) | (~size_b & ~size_h & (addr[1:0] == 2'b00));
    assign issue   = (state == IDLE) && access && aligned;
    assign expired = (tcnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        stall     = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_gnt)
                    state_nxt = bus_we ? DONE : WAIT_R;
                else if (expired)
                    state_nxt = DONE;
            end
            WAIT_R: begin
                stall = 1'b1;
                if (bus_rvalid || expired)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Store data is replicated across lanes so the slave can pick it up from whichever lanes are enabled.
    always_comb begin
        be_nxt    = 4'hF;
        wdata_nxt = wr_data;
        if (size_b) begin
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {4{wr_data[7:0]}};
        end else if (size_h) begin
            be_nxt    = 4'b0011 << {addr[1], 1'b0};
            wdata_nxt = {2{wr_data[15:0]}};
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (fn_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tcnt      <= 8'h0;
            off_q     <= 2'b00;
            fn_q      <= 3'b000;
            rd_data   <= 32'h0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
        end else begin
            state   <= state_nxt;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_nxt;
                        bus_wdata <= wdata_nxt;
                        off_q     <= addr[1:0];
                        fn_q      <= funct;
                        tcnt      <= 8'h0;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        tcnt    <= 8'h0;
                    end else if (expired) begin
                        bus_req <= 1'b0;
                        rd_data <= 32'h0;
                        bus_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'h1;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        rd_data <= ld_fmt;
                    end else if (expired) begin
                        rd_data <= 32'h0;
                        bus_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
